// File: rtl/uart_pkg.sv
// Shared UART definitions: feed FSM encoding, byte width, baud-select codes.
// No logic; imported by the transmit-side buffer and its interface.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } tx_feed_state_t;

    localparam int UART_DATA_W = 8;

    localparam logic [2:0] BAUD_9600   = 3'b001;
    localparam logic [2:0] BAUD_19200  = 3'b010;
    localparam logic [2:0] BAUD_38400  = 3'b011;
    localparam logic [2:0] BAUD_57600  = 3'b100;
    localparam logic [2:0] BAUD_115200 = 3'b101;

    // Even parity bit: makes the total count of ones in data+parity even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port, status flags and transmitter handshake of the TX buffer.
// master = host/transmitter side, slave = the buffer itself.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
);
    logic                     wr_en;
    logic [DATA_W-1:0]        wr_data;
    logic                     flush;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     err_timeout;
    logic [DATA_W-1:0]        data_in_Tx;
    logic                     ena_Tx;
    logic                     busy_Tx;

    modport master (
        output wr_en, wr_data, flush, busy_Tx,
        input  full, empty, count, overflow, err_timeout, data_in_Tx, ena_Tx
    );

    modport slave (
        input  wr_en, wr_data, flush, busy_Tx,
        output full, empty, count, overflow, err_timeout, data_in_Tx, ena_Tx
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, 1-cycle write-to-flag latency; head byte readable combinationally.
// Writes while full are dropped and set a sticky overflow; flush clears contents and flag.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DATA_W-1:0]      head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_nxt;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign head_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                // A pop in the same cycle does not make room for this write.
                if (push && full) overflow <= 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers host bytes and feeds the UART transmitter via ena_Tx/busy_Tx; request 2 cycles after a write into an idle, empty buffer.
// Host is never stalled (drops + overflow when full); a request unanswered for ACK_TIMEOUT cycles is abandoned and retried.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = UART_DATA_W,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    tx_feed_state_t    state;
    tx_feed_state_t    state_nxt;
    logic [TW-1:0]     tmo_cnt;
    logic [DATA_W-1:0] tx_byte;
    logic [DATA_W-1:0] head_dat;
    logic              err_tmo;
    logic              fifo_empty;
    logic              load;
    logic              pop;
    logic              tmo_hit;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.wr_en),
        .push_dat (bus.wr_data),
        .pop      (pop),
        .flush    (bus.flush),
        .head_dat (head_dat),
        .full     (bus.full),
        .empty    (fifo_empty),
        .count    (bus.count),
        .overflow (bus.overflow)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !bus.busy_Tx && !bus.flush) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (bus.busy_Tx) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            // An in-flight frame is never aborted, not even by flush.
            SEND: begin
                if (!bus.busy_Tx) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            tx_byte <= '0;
            err_tmo <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                tx_byte <= head_dat;
                tmo_cnt <= '0;
            end else if (state == REQ && !bus.busy_Tx) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (bus.flush)
                err_tmo <= 1'b0;
            else if (tmo_hit)
                err_tmo <= 1'b1;
        end
    end

    assign bus.empty       = fifo_empty;
    assign bus.err_timeout = err_tmo;
    assign bus.data_in_Tx  = tx_byte;
    assign bus.ena_Tx      = (state == REQ);

endmodule
